// File: rtl/dac_sample_scheduler_if.sv
// Bundle of pacing controls, the two valid/ready sample sources and the registered DAC outputs.
// The slave modport is the scheduler; the master modport is whatever drives it.
interface dac_sample_scheduler_if #(
    parameter int DIV_W = 16
);
    logic             en;
    logic [DIV_W-1:0] rate_div;
    logic             prio_mode;
    logic             comp_ready;
    logic             src0_valid;
    logic [27:0]      src0_data;
    logic             src0_ready;
    logic             src1_valid;
    logic [27:0]      src1_data;
    logic             src1_ready;
    logic [13:0]      dac_ch1;
    logic [13:0]      dac_ch2;
    logic             sample_strobe;
    logic [1:0]       grant;
    logic [15:0]      underrun_cnt;

    modport master (
        output en, rate_div, prio_mode, comp_ready,
        output src0_valid, src0_data, src1_valid, src1_data,
        input  src0_ready, src1_ready,
        input  dac_ch1, dac_ch2, sample_strobe, grant, underrun_cnt
    );

    modport slave (
        input  en, rate_div, prio_mode, comp_ready,
        input  src0_valid, src0_data, src1_valid, src1_data,
        output src0_ready, src1_ready,
        output dac_ch1, dac_ch2, sample_strobe, grant, underrun_cnt
    );
endinterface

// File: rtl/dac_sample_scheduler.sv
// Paced two-source sample arbiter: one slot every rate_div+1 cycles while comp_ready is high,
// granted round-robin or src0-first, with hold/idle-fill and a saturating count on underrun.
module dac_sample_scheduler #(
    parameter logic [13:0] IDLE_CODE = 14'd8192,
    parameter bit          HOLD_LAST = 1'b1,
    parameter int          DIV_W     = 16
) (
    input logic                   clk_design,
    input logic                   rst_n,
    dac_sample_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

    localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [DIV_W-1:0] cnt_p0, cnt_nxt;
    logic             terminal_p0;
    logic             tick_p0;
    logic             sel0_p0, sel1_p0;
    logic             last_src1;
    logic [13:0]      ch1_p1, ch2_p1;
    logic [1:0]       grant_p1;
    logic             vld_p1;
    logic [15:0]      ucnt_p1;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // A live rate_div below the current count is treated as terminal.
    assign terminal_p0 = (cnt_p0 >= bus.rate_div);

    always_ff @(posedge clk_design or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt_p0 <= '0;
        end else begin
            state  <= state_nxt;
            cnt_p0 <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_p0;
        if (!bus.en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
                RUN: begin
                    if (!terminal_p0)
                        cnt_nxt = cnt_p0 + CNT_ONE;
                    else if (bus.comp_ready)
                        cnt_nxt = '0;
                    else
                        state_nxt = STALL;
                end
                STALL: begin
                    if (bus.comp_ready) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        tick_p0 = 1'b0;
        if (bus.en && bus.comp_ready)
            tick_p0 = (state == STALL) || ((state == RUN) && terminal_p0);
        if (bus.prio_mode) begin
            sel0_p0 = bus.src0_valid;
            sel1_p0 = bus.src1_valid & ~bus.src0_valid;
        end else begin
            sel0_p0 = bus.src0_valid & (~bus.src1_valid | last_src1);
            sel1_p0 = bus.src1_valid & (~bus.src0_valid | ~last_src1);
        end
        bus.src0_ready = tick_p0 & sel0_p0;
        bus.src1_ready = tick_p0 & sel1_p0;
    end

    // ---- tick cycle -> registered DAC outputs ----
    always_ff @(posedge clk_design or negedge rst_n) begin
        if (!rst_n) begin
            ch1_p1    <= IDLE_CODE;
            ch2_p1    <= IDLE_CODE;
            grant_p1  <= 2'b00;
            vld_p1    <= 1'b0;
            ucnt_p1   <= 16'd0;
            last_src1 <= 1'b1;
        end else if (!bus.en) begin
            ch1_p1   <= IDLE_CODE;
            ch2_p1   <= IDLE_CODE;
            grant_p1 <= 2'b00;
            vld_p1   <= 1'b0;
        end else if (tick_p0) begin
            vld_p1 <= 1'b1;
            if (sel0_p0 || sel1_p0) begin
                ch1_p1   <= sel0_p0 ? bus.src0_data[27:14] : bus.src1_data[27:14];
                ch2_p1   <= sel0_p0 ? bus.src0_data[13:0]  : bus.src1_data[13:0];
                grant_p1 <= {sel1_p0, sel0_p0};
                if (!bus.prio_mode)
                    last_src1 <= sel1_p0;
            end else begin
                grant_p1 <= 2'b00;
                ucnt_p1  <= sat_inc16(ucnt_p1);
                if (!HOLD_LAST) begin
                    ch1_p1 <= IDLE_CODE;
                    ch2_p1 <= IDLE_CODE;
                end
            end
        end else begin
            vld_p1 <= 1'b0;
        end
    end

    assign bus.dac_ch1       = ch1_p1;
    assign bus.dac_ch2       = ch2_p1;
    assign bus.grant         = grant_p1;
    assign bus.sample_strobe = vld_p1;
    assign bus.underrun_cnt  = ucnt_p1;
endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Randomized bench for dac_sample_scheduler: a slot-level reference model predicts readys and
// queues each slot's outcome; a separate monitor pops and compares on every sample_strobe.
module tb_dac_sample_scheduler;
    localparam logic [13:0] IDLE = 14'd8192;

    typedef struct {
        logic [13:0] ch1;
        logic [13:0] ch2;
        logic [1:0]  grant;
        logic [15:0] ucnt;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t sbq[$];

    dac_sample_scheduler_if #(.DIV_W(16)) bus();

    dac_sample_scheduler #(
        .IDLE_CODE(14'd8192),
        .HOLD_LAST(1'b1),
        .DIV_W(16)
    ) dut (
        .clk_design(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete, cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [27:0] rnd28();
        return 28'($urandom);
    endfunction

    // Reference model state: slot pacing expressed as "cycles into the current slot" plus a
    // pending flag for a slot that is due but waiting on comp_ready.
    bit          m_run = 0;
    int          m_phase = 0;
    bit          m_pend = 0;
    int          m_last = 1;
    logic [13:0] m_ch1 = IDLE;
    logic [13:0] m_ch2 = IDLE;
    logic [1:0]  m_grant = 2'b00;
    bit          m_strobe = 0;
    logic [15:0] m_ucnt = 16'd0;

    initial forever begin
        bit   tick;
        int   win;
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_rdy0", 32'(bus.src0_ready), 32'd0);
            chk("rst_rdy1", 32'(bus.src1_ready), 32'd0);
            m_run = 0; m_phase = 0; m_pend = 0; m_last = 1;
            m_ch1 = IDLE; m_ch2 = IDLE; m_grant = 2'b00; m_strobe = 0; m_ucnt = 16'd0;
            sbq.delete();
        end else begin
            chk("out_ch1", 32'(bus.dac_ch1), 32'(m_ch1));
            chk("out_ch2", 32'(bus.dac_ch2), 32'(m_ch2));
            chk("out_grant", 32'(bus.grant), 32'(m_grant));
            chk("out_strobe", 32'(bus.sample_strobe), 32'(m_strobe));
            chk("out_ucnt", 32'(bus.underrun_cnt), 32'(m_ucnt));
            tick = m_run && bus.en && bus.comp_ready && (m_pend || m_phase >= int'(bus.rate_div));
            if (bus.src0_valid && bus.src1_valid)
                win = bus.prio_mode ? 0 : ((m_last == 0) ? 1 : 0);
            else if (bus.src0_valid)
                win = 0;
            else if (bus.src1_valid)
                win = 1;
            else
                win = -1;
            chk("ready0", 32'(bus.src0_ready), 32'(tick && win == 0));
            chk("ready1", 32'(bus.src1_ready), 32'(tick && win == 1));
            m_strobe = 0;
            if (!bus.en) begin
                m_run = 0; m_phase = 0; m_pend = 0;
                m_ch1 = IDLE; m_ch2 = IDLE; m_grant = 2'b00;
            end else if (tick) begin
                m_strobe = 1;
                if (win >= 0) begin
                    m_ch1 = (win == 0) ? bus.src0_data[27:14] : bus.src1_data[27:14];
                    m_ch2 = (win == 0) ? bus.src0_data[13:0] : bus.src1_data[13:0];
                    m_grant = (win == 0) ? 2'b01 : 2'b10;
                    if (!bus.prio_mode) m_last = win;
                end else begin
                    m_grant = 2'b00;
                    if (m_ucnt != 16'hFFFF) m_ucnt = m_ucnt + 16'd1;
                end
                e.ch1 = m_ch1; e.ch2 = m_ch2; e.grant = m_grant; e.ucnt = m_ucnt; e.cyc = cyc;
                sbq.push_back(e);
                m_phase = 0; m_pend = 0;
            end else if (!m_run) begin
                m_run = 1; m_phase = 0;
            end else if (m_pend || m_phase >= int'(bus.rate_div)) begin
                m_pend = 1;
            end else begin
                m_phase++;
            end
        end
    end

    // Scoreboard monitor: every strobe must match the slot queued one cycle earlier.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n) begin
            if (bus.sample_strobe) begin
                if (sbq.size() == 0 || sbq[0].cyc != cyc - 1) begin
                    checks++; failures++;
                    $display("FAIL sb_unexpected_strobe: got strobe with no slot due (cyc %0d)", cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_ch1", 32'(bus.dac_ch1), 32'(e.ch1));
                    chk("sb_ch2", 32'(bus.dac_ch2), 32'(e.ch2));
                    chk("sb_grant", 32'(bus.grant), 32'(e.grant));
                    chk("sb_ucnt", 32'(bus.underrun_cnt), 32'(e.ucnt));
                end
            end else if (sbq.size() > 0 && sbq[0].cyc <= cyc - 1) begin
                checks++; failures++;
                $display("FAIL sb_missing_strobe: got no strobe, expected slot from cyc %0d", sbq[0].cyc);
                void'(sbq.pop_front());
            end
        end
    end

    task automatic drive(input bit e, input int rd, input bit pm, input bit cr,
                         input bit v0, input bit v1, input logic [27:0] d0, input logic [27:0] d1);
        @(posedge clk); #1;
        bus.en = e; bus.rate_div = 16'(rd); bus.prio_mode = pm; bus.comp_ready = cr;
        bus.src0_valid = v0; bus.src0_data = d0; bus.src1_valid = v1; bus.src1_data = d1;
    endtask

    task automatic async_reset();
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("t1_ch1", 32'(bus.dac_ch1), 32'(IDLE));
        chk("t1_ch2", 32'(bus.dac_ch2), 32'(IDLE));
        chk("t1_grant", 32'(bus.grant), 32'd0);
        chk("t1_ucnt", 32'(bus.underrun_cnt), 32'd0);
        chk("t1_rdy", 32'({bus.src0_ready, bus.src1_ready}), 32'd0);
        bus.en = 1'b0; bus.src0_valid = 1'b0; bus.src1_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic underruns(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 1, 0, 0, rnd28(), rnd28());
        drive(1, 0, 0, 0, 0, 0, rnd28(), rnd28());
        @(negedge clk);
    endtask

    initial begin
        int n0, n1, s;
        int rd;
        bit pm;
        bus.en = 0; bus.rate_div = '0; bus.prio_mode = 0; bus.comp_ready = 0;
        bus.src0_valid = 0; bus.src0_data = '0; bus.src1_valid = 0; bus.src1_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ch1", 32'(bus.dac_ch1), 32'(IDLE));
        chk("rst_grant", 32'(bus.grant), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // round-robin from reset: first grant src0, then alternate
        for (int k = 0; k < 10; k++) begin
            drive(1, 0, 0, 1, 1, 1, rnd28(), rnd28());
            @(negedge clk);
            if (k >= 1) begin
                chk("t3_rdy0", 32'(bus.src0_ready), 32'(k % 2 == 1));
                chk("t3_rdy1", 32'(bus.src1_ready), 32'(k % 2 == 0));
            end
        end

        // pacing: rate_div=3 gives exactly 25 strobes in any 100-cycle window
        for (int k = 0; k < 8; k++) drive(1, 3, 0, 1, 1, 0, rnd28(), rnd28());
        s = 0;
        for (int k = 0; k < 100; k++) begin
            drive(1, 3, 0, 1, 1, 0, rnd28(), rnd28());
            @(negedge clk);
            s += int'(bus.sample_strobe);
        end
        chk("t2_strobes", 32'(s), 32'd25);

        // fixed priority: src1 starved while src0 valid, then granted
        drive(0, 0, 1, 1, 0, 0, rnd28(), rnd28());
        n0 = 0; n1 = 0;
        for (int k = 0; k < 20; k++) begin
            drive(1, 0, 1, 1, 1, 1, rnd28(), rnd28());
            @(negedge clk);
            n0 += int'(bus.src0_ready); n1 += int'(bus.src1_ready);
        end
        chk("t4_src1_starved", 32'(n1), 32'd0);
        chk("t4_src0_grants", 32'(n0), 32'd19);
        drive(1, 0, 1, 1, 0, 1, rnd28(), rnd28());
        @(negedge clk);
        chk("t4_src1_next", 32'(bus.src1_ready), 32'd1);

        // backpressure at terminal, then restart from 0
        drive(0, 4, 0, 0, 0, 0, rnd28(), rnd28());
        n0 = 0; s = 0;
        for (int k = 0; k < 16; k++) begin
            drive(1, 4, 0, 0, 1, 0, rnd28(), rnd28());
            @(negedge clk);
            n0 += int'(bus.src0_ready);
            if (k >= 6) s += int'(bus.sample_strobe);
        end
        chk("t5_stall_rdy", 32'(n0), 32'd0);
        chk("t5_stall_strobe", 32'(s), 32'd0);
        drive(1, 4, 0, 1, 1, 0, rnd28(), rnd28());
        @(negedge clk);
        chk("t5_release_tick", 32'(bus.src0_ready), 32'd1);
        n0 = 0;
        for (int k = 0; k < 4; k++) begin
            drive(1, 4, 0, 1, 1, 0, rnd28(), rnd28());
            @(negedge clk);
            if (k == 0) chk("t5_strobe", 32'(bus.sample_strobe), 32'd1);
            n0 += int'(bus.src0_ready);
        end
        chk("t5_restart_gap", 32'(n0), 32'd0);
        drive(1, 4, 0, 1, 1, 0, rnd28(), rnd28());
        @(negedge clk);
        chk("t5_next_tick", 32'(bus.src0_ready), 32'd1);

        // random traffic, live rate_div changes, enable drops and a mid-run reset
        rd = 2; pm = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 19) == 0) rd = int'($urandom_range(0, 5));
            if ($urandom_range(0, 49) == 0) pm = ~pm;
            if (i == 1000) async_reset();
            drive($urandom_range(0, 15) != 0, rd, pm, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, rnd28(), rnd28());
        end

        // underrun hold and counter saturation
        async_reset();
        drive(1, 0, 0, 1, 0, 0, rnd28(), rnd28());
        drive(1, 0, 0, 1, 1, 0, {14'd100, 14'd200}, rnd28());
        underruns(5);
        chk("t6_ch1", 32'(bus.dac_ch1), 32'd100);
        chk("t6_ch2", 32'(bus.dac_ch2), 32'd200);
        chk("t6_grant", 32'(bus.grant), 32'd0);
        chk("t6_ucnt5", 32'(bus.underrun_cnt), 32'd5);
        underruns(65529);
        chk("t6_ucnt_fffe", 32'(bus.underrun_cnt), 32'h0000FFFE);
        underruns(3);
        chk("t6_ucnt_sat", 32'(bus.underrun_cnt), 32'h0000FFFF);
        underruns(2);
        chk("t6_ucnt_stay", 32'(bus.underrun_cnt), 32'h0000FFFF);
        chk("t6_hold_ch1", 32'(bus.dac_ch1), 32'd100);

        repeat (3) drive(0, 0, 0, 1, 0, 0, rnd28(), rnd28());
        @(negedge clk);
        chk("sb_drain", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
